branch_predictor: RTL and testbench

- IF-stage dynamic branch predictor: direct-mapped BTB plus per-entry 2-bit saturating counters.
- Looks up the fetch PC and gives a registered taken/target prediction one cycle later.
- Trained by EXE-stage resolution, the same point where branch outcomes raise ID_Flush.
- Redirects fetch early so that correctly predicted taken branches avoid the EXE-resolved flush penalty.

---
 rtl/branch_predictor_pkg.sv | 31 +++
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor_btb_table.sv | 60 ++++++
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the IF-stage branch predictor: counter encoding, BTB entry
// layout and the 2-bit saturating counter update.
package bp_pkg;

    localparam int BTB_ENTRIES_DEF = 64;
    localparam int TAG_W_DEF       = 8;
    // Entry tag field is sized for the widest legal tag; only TAG_W LSBs are stored.
    localparam int TAG_W_MAX       = 28;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } BpCtr;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        BpCtr                 ctr;
    } BtbEntry;

    function automatic BpCtr sat_update(input BpCtr ctr, input logic taken);
        BpCtr nxt;
        if (taken) nxt = (ctr == ST)  ? ST  : BpCtr'(ctr + 2'b01);
        else       nxt = (ctr == SNT) ? SNT : BpCtr'(ctr - 2'b01);
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup / prediction and EXE-side training signals of the predictor.
interface branch_predictor_if;

    logic        IF_Req;
    logic        IF_Stall;
    logic        IF_Flush;
    logic [31:0] IF_PC;

    logic        Pred_Valid;
    logic [31:0] Pred_PC;
    logic        Pred_Taken;
    logic [31:0] Pred_Target;

    logic        EXE_Update;
    logic [31:0] EXE_PC;
    logic        EXE_Taken;
    logic [31:0] EXE_Target;

    modport master (
        output IF_Req, IF_Stall, IF_Flush, IF_PC,
        output EXE_Update, EXE_PC, EXE_Taken, EXE_Target,
        input  Pred_Valid, Pred_PC, Pred_Taken, Pred_Target
    );

    modport slave (
        input  IF_Req, IF_Stall, IF_Flush, IF_PC,
        input  EXE_Update, EXE_PC, EXE_Taken, EXE_Target,
        output Pred_Valid, Pred_PC, Pred_Taken, Pred_Target
    );

endinterface

// File: rtl/branch_predictor_btb_table.sv
// Flop-based BTB storage with async clear, two combinational read ports
// (fetch lookup and EXE update) and one write port.
module btb_table
    import bp_pkg::*;
#(
    parameter  int ENTRIES = BTB_ENTRIES_DEF,
    parameter  int TAG_W   = TAG_W_DEF,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IDX_W-1:0] i_rd_idx_a,
    output BtbEntry          o_rd_entry_a,
    input  logic [IDX_W-1:0] i_rd_idx_b,
    output BtbEntry          o_rd_entry_b,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  BtbEntry          i_wr_entry
);

    logic [ENTRIES-1:0]            r_valid;
    logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
    logic [ENTRIES-1:0][31:0]      r_target;
    BpCtr                          r_ctr [ENTRIES];

    logic w_unused;
    assign w_unused = ^i_wr_entry.tag;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid  <= '0;
            r_tag    <= '0;
            r_target <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= WNT;
        end else if (i_we) begin
            r_valid[i_wr_idx]  <= i_wr_entry.valid;
            r_tag[i_wr_idx]    <= i_wr_entry.tag[TAG_W-1:0];
            r_target[i_wr_idx] <= i_wr_entry.target;
            r_ctr[i_wr_idx]    <= i_wr_entry.ctr;
        end
    end

    // Reads return pre-write contents, giving read-before-write on a same-index collision.
    always_comb begin
        o_rd_entry_a                  = '0;
        o_rd_entry_a.valid            = r_valid[i_rd_idx_a];
        o_rd_entry_a.tag[TAG_W-1:0]   = r_tag[i_rd_idx_a];
        o_rd_entry_a.target           = r_target[i_rd_idx_a];
        o_rd_entry_a.ctr              = r_ctr[i_rd_idx_a];
    end

    always_comb begin
        o_rd_entry_b                  = '0;
        o_rd_entry_b.valid            = r_valid[i_rd_idx_b];
        o_rd_entry_b.tag[TAG_W-1:0]   = r_tag[i_rd_idx_b];
        o_rd_entry_b.target           = r_target[i_rd_idx_b];
        o_rd_entry_b.ctr              = r_ctr[i_rd_idx_b];
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BTB with 2-bit counters,
// registered prediction one cycle after lookup, trained from EXE resolution.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter  int TAG_W       = TAG_W_DEF,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic               clk,
    input  logic               resetn,
    branch_predictor_if.slave  bp
);

    logic [IDX_W-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    BtbEntry          w_lk_ent, w_up_ent, w_wr_ent;
    logic             w_lk_hit, w_lk_taken, w_up_hit, w_we;
    logic             w_unused;

    logic             r_pred_valid;
    logic [31:0]      r_pred_pc;
    logic             r_pred_taken;
    logic [31:0]      r_pred_target;

    assign w_lk_idx = bp.IF_PC[IDX_W+1:2];
    assign w_lk_tag = bp.IF_PC[IDX_W+2 +: TAG_W];
    assign w_up_idx = bp.EXE_PC[IDX_W+1:2];
    assign w_up_tag = bp.EXE_PC[IDX_W+2 +: TAG_W];
    assign w_unused = ^{bp.EXE_PC, w_lk_ent.tag, w_up_ent.tag};

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk          (clk),
        .resetn       (resetn),
        .i_rd_idx_a   (w_lk_idx),
        .o_rd_entry_a (w_lk_ent),
        .i_rd_idx_b   (w_up_idx),
        .o_rd_entry_b (w_up_ent),
        .i_we         (w_we),
        .i_wr_idx     (w_up_idx),
        .i_wr_entry   (w_wr_ent)
    );

    assign w_lk_hit   = w_lk_ent.valid && (w_lk_ent.tag[TAG_W-1:0] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && w_lk_ent.ctr[1];
    assign w_up_hit   = w_up_ent.valid && (w_up_ent.tag[TAG_W-1:0] == w_up_tag);

    // A miss that resolves not-taken leaves the table alone; a taken miss replaces the entry.
    always_comb begin
        w_we     = 1'b0;
        w_wr_ent = w_up_ent;
        if (bp.EXE_Update) begin
            if (w_up_hit) begin
                w_we         = 1'b1;
                w_wr_ent.ctr = sat_update(w_up_ent.ctr, bp.EXE_Taken);
                if (bp.EXE_Taken) w_wr_ent.target = bp.EXE_Target;
            end else if (bp.EXE_Taken) begin
                w_we                       = 1'b1;
                w_wr_ent                   = '0;
                w_wr_ent.valid             = 1'b1;
                w_wr_ent.tag[TAG_W-1:0]    = w_up_tag;
                w_wr_ent.target            = bp.EXE_Target;
                w_wr_ent.ctr               = WT;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pred_valid  <= 1'b0;
            r_pred_pc     <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (bp.IF_Flush) begin
            r_pred_valid  <= 1'b0;
            r_pred_pc     <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (!bp.IF_Stall) begin
            if (bp.IF_Req) begin
                r_pred_valid  <= 1'b1;
                r_pred_pc     <= bp.IF_PC;
                r_pred_taken  <= w_lk_taken;
                r_pred_target <= w_lk_taken ? w_lk_ent.target : 32'h0;
            end else begin
                r_pred_valid  <= 1'b0;
                r_pred_pc     <= '0;
                r_pred_taken  <= 1'b0;
                r_pred_target <= '0;
            end
        end
    end

    assign bp.Pred_Valid  = r_pred_valid;
    assign bp.Pred_PC     = r_pred_pc;
    assign bp.Pred_Taken  = r_pred_taken;
    assign bp.Pred_Target = r_pred_target;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each task drives one scenario and checks inline.
module tb_branch_predictor;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    branch_predictor_if bp_if ();

    branch_predictor dut (
        .clk    (clk),
        .resetn (resetn),
        .bp     (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] PC_A  = 32'h0040_0010; // idx 4, tag 0x00
    localparam logic [31:0] PC_B  = 32'h0040_0110; // idx 4, tag 0x01
    localparam logic [31:0] PC_C  = 32'h0040_0020; // idx 8
    localparam logic [31:0] PC_D  = 32'h0040_0030; // idx 12

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp_if.IF_Req     = 1'b0;
        bp_if.IF_Stall   = 1'b0;
        bp_if.IF_Flush   = 1'b0;
        bp_if.IF_PC      = 32'h0;
        bp_if.EXE_Update = 1'b0;
        bp_if.EXE_PC     = 32'h0;
        bp_if.EXE_Taken  = 1'b0;
        bp_if.EXE_Target = 32'h0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bp_if.IF_Req     = 1'b0;
        bp_if.EXE_Update = 1'b1;
        bp_if.EXE_PC     = pc;
        bp_if.EXE_Taken  = tk;
        bp_if.EXE_Target = tgt;
        tick();
        bp_if.EXE_Update = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        bp_if.IF_Req = 1'b1;
        bp_if.IF_PC  = pc;
        tick();
        bp_if.IF_Req = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        total += 4;
        if (bp_if.Pred_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bp_if.Pred_Valid); end
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b want=0", bp_if.Pred_Taken); end
        if (bp_if.Pred_PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bp_if.Pred_PC); end
        if (bp_if.Pred_Target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h want=0", bp_if.Pred_Target); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_cold_lookup();
        do_lookup(PC_A);
        total += 4;
        if (bp_if.Pred_Valid !== 1'b1) begin bad++; $display("FAIL cold_valid got=%b want=1", bp_if.Pred_Valid); end
        if (bp_if.Pred_PC !== PC_A) begin bad++; $display("FAIL cold_pc got=%h want=%h", bp_if.Pred_PC, PC_A); end
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL cold_taken got=%b want=0", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0) begin bad++; $display("FAIL cold_target got=%h want=0", bp_if.Pred_Target); end
    endtask

    task automatic test_req_low();
        tick();
        total++;
        if (bp_if.Pred_Valid !== 1'b0) begin bad++; $display("FAIL req_low_valid got=%b want=0", bp_if.Pred_Valid); end
    endtask

    task automatic test_alloc();
        do_update(PC_A, 1'b1, 32'h0040_0100);
        do_lookup(PC_A);
        total += 2;
        if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%b want=1", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0040_0100) begin bad++; $display("FAIL alloc_target got=%h want=00400100", bp_if.Pred_Target); end
    endtask

    task automatic test_counter();
        // 10 -> 01 -> 00
        do_update(PC_A, 1'b0, 32'h0);
        do_update(PC_A, 1'b0, 32'h0);
        do_lookup(PC_A);
        total += 2;
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL ctr_snt_taken got=%b want=0", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0) begin bad++; $display("FAIL ctr_snt_target got=%h want=0", bp_if.Pred_Target); end
        // 00 -> 01: still not taken
        do_update(PC_A, 1'b1, 32'h0040_0200);
        do_lookup(PC_A);
        total++;
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL ctr_wnt_taken got=%b want=0", bp_if.Pred_Taken); end
        // 01 -> 10 -> 11, fourth taken holds 11, then one not-taken leaves 10
        do_update(PC_A, 1'b1, 32'h0040_0200);
        do_update(PC_A, 1'b1, 32'h0040_0200);
        do_update(PC_A, 1'b1, 32'h0040_0240);
        do_lookup(PC_A);
        total += 2;
        if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL ctr_st_taken got=%b want=1", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0040_0240) begin bad++; $display("FAIL ctr_st_target got=%h want=00400240", bp_if.Pred_Target); end
        do_update(PC_A, 1'b0, 32'h0);
        do_lookup(PC_A);
        total += 2;
        if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL ctr_sat_taken got=%b want=1", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0040_0240) begin bad++; $display("FAIL ctr_sat_target got=%h want=00400240", bp_if.Pred_Target); end
    endtask

    task automatic test_alias();
        do_update(PC_B, 1'b1, 32'h0040_0300);
        do_lookup(PC_A);
        total += 2;
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL alias_a_taken got=%b want=0", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0) begin bad++; $display("FAIL alias_a_target got=%h want=0", bp_if.Pred_Target); end
        do_lookup(PC_B);
        total += 2;
        if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL alias_b_taken got=%b want=1", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0040_0300) begin bad++; $display("FAIL alias_b_target got=%h want=00400300", bp_if.Pred_Target); end
    endtask

    task automatic test_stall_flush();
        bp_if.IF_Req = 1'b1;
        bp_if.IF_PC  = PC_B;
        tick();
        bp_if.IF_Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bp_if.IF_PC = PC_A + 32'(i * 4);
            tick();
            total += 4;
            if (bp_if.Pred_Valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, bp_if.Pred_Valid); end
            if (bp_if.Pred_PC !== PC_B) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=%h", i, bp_if.Pred_PC, PC_B); end
            if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL stall_taken[%0d] got=%b want=1", i, bp_if.Pred_Taken); end
            if (bp_if.Pred_Target !== 32'h0040_0300) begin bad++; $display("FAIL stall_target[%0d] got=%h want=00400300", i, bp_if.Pred_Target); end
        end
        // flush wins over stall
        bp_if.IF_Flush = 1'b1;
        tick();
        total += 2;
        if (bp_if.Pred_Valid !== 1'b0) begin bad++; $display("FAIL flush_stall_valid got=%b want=0", bp_if.Pred_Valid); end
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL flush_stall_taken got=%b want=0", bp_if.Pred_Taken); end
        bp_if.IF_Stall = 1'b0;
        bp_if.IF_PC    = PC_B;
        tick();
        total++;
        if (bp_if.Pred_Valid !== 1'b0) begin bad++; $display("FAIL flush_req_valid got=%b want=0", bp_if.Pred_Valid); end
        bp_if.IF_Flush = 1'b0;
        bp_if.IF_Req   = 1'b0;
    endtask

    task automatic test_same_cycle();
        bp_if.IF_Req     = 1'b1;
        bp_if.IF_PC      = PC_C;
        bp_if.EXE_Update = 1'b1;
        bp_if.EXE_PC     = PC_C;
        bp_if.EXE_Taken  = 1'b1;
        bp_if.EXE_Target = 32'h0040_0400;
        tick();
        bp_if.EXE_Update = 1'b0;
        total += 2;
        if (bp_if.Pred_Valid !== 1'b1) begin bad++; $display("FAIL rbw_valid got=%b want=1", bp_if.Pred_Valid); end
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL rbw_old_taken got=%b want=0", bp_if.Pred_Taken); end
        tick();
        bp_if.IF_Req = 1'b0;
        total += 2;
        if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL rbw_new_taken got=%b want=1", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0040_0400) begin bad++; $display("FAIL rbw_new_target got=%h want=00400400", bp_if.Pred_Target); end
    endtask

    task automatic test_back_to_back();
        // alloc (WT) then not-taken hit -> WNT; lost second update would leave it taken
        do_update(PC_D, 1'b1, 32'h0040_0500);
        do_update(PC_D, 1'b0, 32'h0);
        do_lookup(PC_D);
        total++;
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL b2b_taken got=%b want=0", bp_if.Pred_Taken); end
    endtask

    task automatic test_mid_reset();
        bp_if.IF_Req = 1'b1;
        bp_if.IF_PC  = PC_B;
        tick();
        total++;
        if (bp_if.Pred_Taken !== 1'b1) begin bad++; $display("FAIL pre_rst_taken got=%b want=1", bp_if.Pred_Taken); end
        resetn = 1'b0;
        #1;
        total += 4;
        if (bp_if.Pred_Valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bp_if.Pred_Valid); end
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL mid_rst_taken got=%b want=0", bp_if.Pred_Taken); end
        if (bp_if.Pred_PC !== 32'h0) begin bad++; $display("FAIL mid_rst_pc got=%h want=0", bp_if.Pred_PC); end
        if (bp_if.Pred_Target !== 32'h0) begin bad++; $display("FAIL mid_rst_target got=%h want=0", bp_if.Pred_Target); end
        bp_if.IF_Req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        do_lookup(PC_B);
        total += 3;
        if (bp_if.Pred_Valid !== 1'b1) begin bad++; $display("FAIL post_rst_valid got=%b want=1", bp_if.Pred_Valid); end
        if (bp_if.Pred_Taken !== 1'b0) begin bad++; $display("FAIL post_rst_taken got=%b want=0", bp_if.Pred_Taken); end
        if (bp_if.Pred_Target !== 32'h0) begin bad++; $display("FAIL post_rst_target got=%h want=0", bp_if.Pred_Target); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b1;
        idle_inputs();
        test_reset();
        test_cold_lookup();
        test_req_low();
        test_alloc();
        test_counter();
        test_alias();
        test_stall_flush();
        test_same_cycle();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
